// File: rtl/mem_access_ctrl_pkg.sv
// Shared encodings for the memory stage: memOp, memSize, fault causes and
// the controller FSM states, plus the captured-request record and the
// alignment rule. Imported by the controller, its lane aligner and the
// EX/MEM latch logic.
package mem_access_ctrl_pkg;

  localparam logic [1:0] OP_NONE   = 2'b00;
  localparam logic [1:0] OP_LOAD_S = 2'b01;
  localparam logic [1:0] OP_STORE  = 2'b10;
  localparam logic [1:0] OP_LOAD_U = 2'b11;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;
  localparam logic [1:0] SIZE_BAD  = 2'b11;

  localparam logic [1:0] CAUSE_NONE    = 2'b00;
  localparam logic [1:0] CAUSE_ALIGN   = 2'b01;
  localparam logic [1:0] CAUSE_BUS     = 2'b10;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'b11;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_REQ  = 2'b01;
  localparam logic [1:0] ST_RESP = 2'b10;
  localparam logic [1:0] ST_DONE = 2'b11;

  // One memory operation as sampled from the EX/MEM latch in IDLE.
  typedef struct packed {
    logic [1:0]  op;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] data;
    logic [4:0]  rd;
  } mem_req_t;

  // Halves need an even address, words a 4-byte aligned one; size 11 is
  // never legal and is reported through the same fault cause.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lsb);
    case (size)
      SIZE_HALF: return lsb[0];
      SIZE_WORD: return lsb != 2'b00;
      SIZE_BAD:  return 1'b1;
      default:   return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// Data-memory bus between the memory-stage controller (master) and the
// data memory (slave).
//   dmemReq/We/Addr/Wdata/Be : request, held until dmemGnt
//   dmemGnt                  : request accepted this cycle
//   dmemRvalid/Rdata/Err     : response or write ack, error qualified by rvalid
interface mem_access_ctrl_if;
  logic        dmemReq;
  logic        dmemWe;
  logic [31:0] dmemAddr;
  logic [31:0] dmemWdata;
  logic [3:0]  dmemBe;
  logic        dmemGnt;
  logic        dmemRvalid;
  logic [31:0] dmemRdata;
  logic        dmemErr;

  modport master (
    output dmemReq, dmemWe, dmemAddr, dmemWdata, dmemBe,
    input  dmemGnt, dmemRvalid, dmemRdata, dmemErr
  );

  modport slave (
    input  dmemReq, dmemWe, dmemAddr, dmemWdata, dmemBe,
    output dmemGnt, dmemRvalid, dmemRdata, dmemErr
  );
endinterface

// File: rtl/mem_access_ctrl_lane_align.sv
// Combinational byte-lane steering for the memory stage.
//   size, addr_lsb     : access size and low address bits
//   store_data         : rs2 value, low bytes significant
//   be, wdata          : store byte enables and lane-replicated write data
//   rdata, sign_ext    : read word and signed/unsigned load flag
//   load_data          : extracted and extended load result
module mem_lane_align
  import mem_access_ctrl_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  addr_lsb,
  input  logic [31:0] store_data,
  input  logic [31:0] rdata,
  input  logic        sign_ext,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] load_data
);

  logic [31:0] lane;

  // Replicating the store data across lanes lets the memory pick the
  // enabled bytes without needing its own shifter.
  always_comb begin
    be    = 4'b1111;
    wdata = store_data;
    case (size)
      SIZE_BYTE: begin
        be    = 4'b0001 << addr_lsb;
        wdata = {4{store_data[7:0]}};
      end
      SIZE_HALF: begin
        be    = addr_lsb[1] ? 4'b1100 : 4'b0011;
        wdata = {2{store_data[15:0]}};
      end
      default: begin
        be    = 4'b1111;
        wdata = store_data;
      end
    endcase
  end

  assign lane = rdata >> {addr_lsb, 3'b000};

  always_comb begin
    load_data = lane;
    case (size)
      SIZE_BYTE: load_data = {{24{sign_ext & lane[7]}}, lane[7:0]};
      SIZE_HALF: load_data = {{16{sign_ext & lane[15]}}, lane[15:0]};
      default:   load_data = lane;
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Memory-stage sequencer: one data-memory transaction per memOp, stalling
// the EX/MEM latch while it is in flight and returning load data/faults.
//   clk, reset            : clock, asynchronous active-high reset
//   memOp..rdIn           : EX/MEM latch fields
//   dmem                  : data-memory bus (master side)
//   memStall              : hold EX/MEM and earlier stages
//   loadValid/Data/Rd     : 1-cycle load writeback pulse
//   memFault, faultCause  : 1-cycle fault pulse and its reason
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [1:0]              memOp,
  input  logic [1:0]              memSize,
  input  logic [31:0]             addr,
  input  logic [31:0]             storeData,
  input  logic [4:0]              rdIn,
  mem_access_ctrl_if.master       dmem,
  output logic                    memStall,
  output logic                    loadValid,
  output logic [31:0]             loadData,
  output logic [4:0]              loadRd,
  output logic                    memFault,
  output logic [1:0]              faultCause
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [1:0]       state_q, state_d;
  mem_req_t         req_q, req_d;
  logic [1:0]       cause_q, cause_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      load_data_q, load_data_d;

  logic             timeout_hit;
  logic             is_store;
  logic             in_req;
  logic             in_done;
  logic [3:0]       lane_be;
  logic [31:0]      lane_wdata;
  logic [31:0]      lane_load;

  mem_lane_align u_align (
    .size       (req_q.size),
    .addr_lsb   (req_q.addr[1:0]),
    .store_data (req_q.data),
    .rdata      (dmem.dmemRdata),
    .sign_ext   (req_q.op == OP_LOAD_S),
    .be         (lane_be),
    .wdata      (lane_wdata),
    .load_data  (lane_load)
  );

  // The counter holds the number of REQ/RESP cycles already spent, so the
  // timeout fires in the TIMEOUT_CYCLES-th such cycle.
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
  assign is_store    = req_q.op == OP_STORE;

  always_comb begin
    state_d     = state_q;
    req_d       = req_q;
    cause_d     = cause_q;
    cnt_d       = cnt_q;
    load_data_d = load_data_q;
    case (state_q)
      ST_IDLE: begin
        if (memOp != OP_NONE) begin
          req_d.op   = memOp;
          req_d.size = memSize;
          req_d.addr = addr;
          req_d.data = storeData;
          req_d.rd   = rdIn;
          cnt_d      = '0;
          if (is_misaligned(memSize, addr[1:0])) begin
            state_d = ST_DONE;
            cause_d = CAUSE_ALIGN;
          end else begin
            state_d = ST_REQ;
            cause_d = CAUSE_NONE;
          end
        end
      end
      // A grant landing on the timeout cycle is abandoned along with the request.
      ST_REQ: begin
        if (timeout_hit) begin
          state_d = ST_DONE;
          cause_d = CAUSE_TIMEOUT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          if (dmem.dmemGnt) state_d = ST_RESP;
        end
      end
      // A response in the timeout cycle still completes the access.
      ST_RESP: begin
        if (dmem.dmemRvalid) begin
          state_d = ST_DONE;
          cause_d = dmem.dmemErr ? CAUSE_BUS : CAUSE_NONE;
          if (!is_store) load_data_d = lane_load;
        end else if (timeout_hit) begin
          state_d = ST_DONE;
          cause_d = CAUSE_TIMEOUT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      req_q       <= '0;
      cause_q     <= CAUSE_NONE;
      cnt_q       <= '0;
      load_data_q <= '0;
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      cause_q     <= cause_d;
      cnt_q       <= cnt_d;
      load_data_q <= load_data_d;
    end
  end

  assign in_req  = state_q == ST_REQ;
  assign in_done = state_q == ST_DONE;

  // Stall releases in DONE so the latch advances on that edge and IDLE
  // sees the following op rather than re-issuing this one.
  assign memStall = ((state_q == ST_IDLE) && (memOp != OP_NONE)) ||
                    in_req || (state_q == ST_RESP);

  assign dmem.dmemReq   = in_req;
  assign dmem.dmemWe    = in_req && is_store;
  assign dmem.dmemAddr  = in_req ? {req_q.addr[31:2], 2'b00} : 32'h0;
  assign dmem.dmemWdata = (in_req && is_store) ? lane_wdata : 32'h0;
  assign dmem.dmemBe    = in_req ? (is_store ? lane_be : 4'b1111) : 4'b0000;

  assign loadValid  = in_done && (cause_q == CAUSE_NONE) && !is_store;
  assign memFault   = in_done && (cause_q != CAUSE_NONE);
  assign faultCause = in_done ? cause_q : CAUSE_NONE;
  assign loadData   = load_data_q;
  assign loadRd     = req_q.rd;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Randomized and directed bench for mem_access_ctrl against a behavioural
// model of stall length, bus request fields, fault cause and load result.
module tb_mem_access_ctrl;

  localparam int TIMEOUT = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  memOp, memSize;
  logic [31:0] addr, storeData;
  logic [4:0]  rdIn;
  logic        memStall, loadValid, memFault;
  logic [31:0] loadData;
  logic [4:0]  loadRd;
  logic [1:0]  faultCause;

  int compare_count = 0;
  int fail_count    = 0;

  mem_access_ctrl_if bus();

  mem_access_ctrl #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clk        (clk),
    .reset      (reset),
    .memOp      (memOp),
    .memSize    (memSize),
    .addr       (addr),
    .storeData  (storeData),
    .rdIn       (rdIn),
    .dmem       (bus),
    .memStall   (memStall),
    .loadValid  (loadValid),
    .loadData   (loadData),
    .loadRd     (loadRd),
    .memFault   (memFault),
    .faultCause (faultCause)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    compare_count++;
    if (actual !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
    end
  endtask

  // Reference load result: shift to the addressed byte, keep the access
  // width, and treat it as a signed or unsigned number.
  function automatic logic [31:0] model_load(input logic [1:0] op, input logic [1:0] size,
                                             input logic [31:0] a, input logic [31:0] rdata);
    longint v;
    longint word = longint'(rdata);
    int     sh   = 8 * int'(a % 4);
    v = word / (longint'(1) << sh);
    if (size == 2'd0) begin
      v = v % 256;
      if (op == 2'b01 && v >= 128) v = v - 256;
    end else if (size == 2'd1) begin
      v = v % 65536;
      if (op == 2'b01 && v >= 32768) v = v - 65536;
    end else begin
      v = word;
    end
    return v[31:0];
  endfunction

  function automatic logic [3:0] model_be(input logic [1:0] size, input logic [31:0] a);
    int lane_no = int'(a % 4);
    if (size == 2'd0) return 4'(1 << lane_no);
    if (size == 2'd1) return (lane_no >= 2) ? 4'd12 : 4'd3;
    return 4'd15;
  endfunction

  function automatic logic [31:0] model_wdata(input logic [1:0] size, input logic [31:0] d);
    if (size == 2'd0) return (d % 256) * 32'h0101_0101;
    if (size == 2'd1) return (d % 65536) * 32'h0001_0001;
    return d;
  endfunction

  task automatic clear_bus();
    bus.dmemGnt    = 1'b0;
    bus.dmemRvalid = 1'b0;
    bus.dmemErr    = 1'b0;
    bus.dmemRdata  = 32'h0;
  endtask

  // Presents one op from the latch and plays the memory side: grant in the
  // gnt_at-th request cycle (0 = never), response rvalid_gap cycles after
  // the first response cycle.
  task automatic applyStimulus(input logic [1:0] op, input logic [1:0] size,
                               input logic [31:0] a, input logic [31:0] sd, input logic [4:0] rd,
                               input int gnt_at, input int rvalid_gap, input logic err,
                               input logic [31:0] rdata, input bit noise);
    bit          misaligned, store, done, granted, field_bad, early_pulse;
    int          exp_stall, exp_req, req_seen, resp_seen, stall_seen;
    logic [1:0]  exp_cause;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;
    done = 0; granted = 0; field_bad = 0; early_pulse = 0;
    req_seen = 0; resp_seen = 0; stall_seen = 0;
    memOp = op; memSize = size; addr = a; storeData = sd; rdIn = rd;

    if (op == 2'b00) begin
      @(negedge clk);
      checkOutput("idle_stall", memStall, 0);
      checkOutput("idle_req", bus.dmemReq, 0);
      checkOutput("idle_pulse", loadValid | memFault, 0);
      @(posedge clk); #1;
      return;
    end

    store      = (op == 2'b10);
    misaligned = (size == 2'd3) || (size == 2'd1 && a % 2 != 0) || (size == 2'd2 && a % 4 != 0);
    exp_be     = store ? model_be(size, a) : 4'hF;
    exp_wdata  = model_wdata(size, sd);
    if (misaligned) begin
      exp_stall = 1; exp_cause = 2'd1; exp_req = 0;
    end else if (gnt_at == 0 || gnt_at + 1 + rvalid_gap > TIMEOUT) begin
      exp_stall = 1 + TIMEOUT; exp_cause = 2'd3;
      exp_req   = (gnt_at == 0 || gnt_at > TIMEOUT) ? TIMEOUT : gnt_at;
    end else begin
      exp_stall = 2 + gnt_at + rvalid_gap; exp_cause = err ? 2'd2 : 2'd0; exp_req = gnt_at;
    end

    for (int cyc = 0; cyc < 64 && !done; cyc++) begin
      @(negedge clk);
      clear_bus();
      bus.dmemRdata = $urandom;
      if (!memStall) begin
        done = 1;
        checkOutput("stall_cycles", stall_seen, exp_stall);
        checkOutput("req_cycles", req_seen, exp_req);
        checkOutput("fault_cause", faultCause, exp_cause);
        checkOutput("mem_fault", memFault, exp_cause != 2'd0);
        checkOutput("load_valid", loadValid, exp_cause == 2'd0 && !store);
        checkOutput("req_stable", field_bad, 0);
        checkOutput("early_pulse", early_pulse, 0);
        if (exp_cause == 2'd0 && !store) begin
          checkOutput("load_data", loadData, model_load(op, size, a, rdata));
          checkOutput("load_rd", loadRd, rd);
        end
      end else begin
        stall_seen++;
        if (loadValid || memFault) early_pulse = 1;
        if (bus.dmemReq) begin
          req_seen++;
          if (req_seen == 1) begin
            checkOutput("req_addr", bus.dmemAddr, a & 32'hFFFF_FFFC);
            checkOutput("req_we", bus.dmemWe, store);
            checkOutput("req_be", bus.dmemBe, exp_be);
            if (store) checkOutput("req_wdata", bus.dmemWdata, exp_wdata);
          end else if (bus.dmemAddr !== (a & 32'hFFFF_FFFC) || bus.dmemBe !== exp_be ||
                       bus.dmemWe !== store || (store && bus.dmemWdata !== exp_wdata)) begin
            field_bad = 1;
          end
          if (req_seen == gnt_at) begin
            bus.dmemGnt = 1'b1;
            granted     = 1;
          end else if (noise && $urandom_range(0, 1) == 1) begin
            bus.dmemRvalid = 1'b1;
            bus.dmemErr    = 1'b1;
          end
        end else if (granted) begin
          if (resp_seen == rvalid_gap) begin
            bus.dmemRvalid = 1'b1;
            bus.dmemErr    = err;
            bus.dmemRdata  = rdata;
          end
          resp_seen++;
        end
      end
    end
    if (!done) checkOutput("done_reached", 0, 1);
    @(posedge clk); #1;
    clear_bus();
    memOp = 2'b00;
  endtask

  initial begin
    logic [1:0]  r_op, r_size;
    logic [31:0] r_addr;
    reset = 1'b1;
    memOp = 2'b00; memSize = 2'b00; addr = 32'h0; storeData = 32'h0; rdIn = 5'd0;
    clear_bus();
    #12;
    checkOutput("rst_req", bus.dmemReq, 0);
    checkOutput("rst_we", bus.dmemWe, 0);
    checkOutput("rst_be", bus.dmemBe, 0);
    checkOutput("rst_addr", bus.dmemAddr, 0);
    checkOutput("rst_wdata", bus.dmemWdata, 0);
    checkOutput("rst_stall", memStall, 0);
    checkOutput("rst_load_valid", loadValid, 0);
    checkOutput("rst_fault", memFault, 0);
    checkOutput("rst_cause", faultCause, 0);
    checkOutput("rst_load_data", loadData, 0);
    checkOutput("rst_load_rd", loadRd, 0);
    reset = 1'b0;
    @(posedge clk); #1;

    applyStimulus(2'b00, 2'b10, 32'h100, 32'h0, 5'd0, 1, 0, 1'b0, 32'h0, 0);
    applyStimulus(2'b01, 2'b10, 32'h100, 32'h0, 5'd3, 1, 1, 1'b0, 32'hDEAD_BEEF, 0);
    applyStimulus(2'b01, 2'b00, 32'h103, 32'h0, 5'd4, 1, 0, 1'b0, 32'h8012_3456, 0);
    applyStimulus(2'b11, 2'b00, 32'h103, 32'h0, 5'd5, 1, 0, 1'b0, 32'h8012_3456, 0);
    applyStimulus(2'b10, 2'b01, 32'h202, 32'h1234_ABCD, 5'd6, 1, 0, 1'b0, 32'h0, 0);
    applyStimulus(2'b01, 2'b10, 32'h102, 32'h0, 5'd7, 1, 0, 1'b0, 32'h0, 0);
    applyStimulus(2'b01, 2'b11, 32'h100, 32'h0, 5'd8, 1, 0, 1'b0, 32'h0, 0);
    applyStimulus(2'b01, 2'b10, 32'h400, 32'h0, 5'd9, 0, 0, 1'b0, 32'h0, 0);
    applyStimulus(2'b11, 2'b01, 32'h402, 32'h0, 5'd10, 2, 0, 1'b1, 32'h1234_5678, 0);
    applyStimulus(2'b01, 2'b10, 32'h404, 32'h0, 5'd11, 2, 1, 1'b0, 32'h0BAD_F00D, 0);

    // Reset while waiting for the response: request and stall drop
    // immediately, the stale response is ignored, and no pulse appears.
    memOp = 2'b01; memSize = 2'b10; addr = 32'h300; rdIn = 5'd12;
    @(negedge clk);
    @(negedge clk);
    checkOutput("mid_req_before", bus.dmemReq, 1);
    bus.dmemGnt = 1'b1;
    @(negedge clk);
    bus.dmemGnt = 1'b0;
    checkOutput("mid_stall_before", memStall, 1);
    #1 reset = 1'b1; memOp = 2'b00;
    #1;
    checkOutput("mid_req_async", bus.dmemReq, 0);
    checkOutput("mid_stall_async", memStall, 0);
    @(posedge clk); #2 reset = 1'b0;
    @(negedge clk);
    bus.dmemRvalid = 1'b1; bus.dmemRdata = 32'hCAFE_F00D;
    @(negedge clk);
    clear_bus();
    checkOutput("late_rvalid_load", loadValid, 0);
    checkOutput("late_rvalid_fault", memFault, 0);
    checkOutput("late_rvalid_stall", memStall, 0);
    @(posedge clk); #1;
    applyStimulus(2'b01, 2'b10, 32'h300, 32'h0, 5'd12, 1, 0, 1'b0, 32'h1357_9BDF, 0);

    for (int n = 0; n < 80; n++) begin
      r_op   = 2'($urandom_range(0, 3));
      r_size = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      r_addr = $urandom;
      if ($urandom_range(0, 9) < 7) begin
        if (r_size == 2'd1) r_addr[0] = 1'b0;
        if (r_size == 2'd2) r_addr[1:0] = 2'b00;
      end
      applyStimulus(r_op, r_size, r_addr, $urandom, 5'($urandom_range(0, 31)),
                    ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 3),
                    $urandom_range(0, 2), ($urandom_range(0, 7) == 0), $urandom, 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, fail_count);
    $finish;
  end

endmodule
